twiddle_stream_gen: RTL and testbench
=====================================

Name: twiddle_stream_gen

Overview:
- Sequential producer of ML-KEM NTT twiddle factors: streams ZETA^i mod Q for i = 0..N-1 over a valid/ready interface.
- Drives the operand side of the KDSP modular multiplier datapath. It is the source end of the operand stream that KDSP consumes.
- Each next power is computed in-block by a bit-serial shift-add modular multiplier. No ROM is used.

Parameters:
- Q, 3329: modulus.
- ZETA, 17: forward primitive 256th root of unity mod Q.
- ZETA_INV, 1175: inverse of ZETA mod Q; used only when INVERSE_EN is defined.
- N, 128: number of factors per sequence.
- W, 12: data width; Q < 2^W.
- IW, 7: index width, $clog2(N).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a sequence; ignored unless idle
- tw_ready  in  1  consumer accepts tw_data this cycle
- tw_valid  out  1  tw_data/tw_idx hold a valid factor
- tw_data  out  W  current factor, always < Q
- tw_idx  out  IW  exponent i of tw_data
- busy  out  1  high from start until the final handshake
- done  out  1  one-cycle pulse on the cycle after the final handshake

Behaviour:
- Reset (async assert, sync release): state IDLE. tw_valid=0, tw_data=0, tw_idx=0, busy=0, done=0; internal accumulator and counters also 0.
- FSM states:
  - IDLE: start=1 -> OUT. On that edge load tw_data=1, tw_idx=0, tw_valid=1, busy=1. First factor is valid the cycle after start.
  - OUT: tw_valid=1; tw_data/tw_idx held stable while tw_ready=0.
    - Handshake (tw_valid & tw_ready) with tw_idx==N-1 -> IDLE. tw_valid=0, busy=0, done=1 for exactly one cycle. tw_data/tw_idx keep their last value.
    - Handshake otherwise -> MUL. tw_valid=0. acc=0, bit counter=W-1, multiplier operand latched = tw_data.
  - MUL: one operand bit per cycle, MSB first, for W cycles.
    - Step: t = 2*acc; if t >= Q then t -= Q. If operand[bit] then t += C; if t >= Q then t -= Q. acc = t.
    - C = ZETA, or ZETA_INV in inverse mode.
    - Intermediate widths W+1 bits. One conditional subtract per add suffices because acc < Q and C < Q.
    - On the W-th MUL edge: tw_data = final acc, tw_idx += 1, tw_valid = 1 -> OUT.
    - Handshake-to-next-valid latency is exactly W clock edges. Throughput is one factor per W+1 cycles with tw_ready held high.
- start while busy is ignored, including a start on the same cycle as the final handshake. A new start is honoured only in IDLE, earliest the cycle done is high.
- tw_ready while tw_valid=0 has no effect.
- Reset asserted mid-sequence aborts immediately to the reset values. No done pulse is produced.
- tw_data never reaches Q.
- tw_idx does not wrap within a sequence. It restarts at 0 only on the next start.

Optional Feature:
- Macro: TWIDDLE_INVERSE_EN.
- Defined:
  - Adds input port inv (1 bit), sampled on the start edge and held internally for the whole sequence.
  - inv=1 selects C=ZETA_INV (sequence ZETA_INV^i, for the inverse NTT). inv=0 selects C=ZETA.
  - Changing inv mid-sequence has no effect.
- Undefined: inv port is absent, C=ZETA always, and ZETA_INV is unused.

Test Plan:
- Reset then start pulse with tw_ready=1: first five outputs (idx 0..4) are 1, 17, 289, 1584, 296. tw_valid reasserts every W+1=13 cycles.
- Full forward run with tw_ready=1: exactly 128 handshakes; idx 127 data = 2154 (= -17^-1 mod 3329); done pulses once the cycle after; busy falls with it; every tw_data < 3329.
- Backpressure: tw_ready held 0 for 20 cycles at idx 2. tw_data stays 289 and tw_valid stays 1 throughout. After release, the next value 1584 appears 12 edges after the handshake.
- start pulses at idx 10 and simultaneously with the final handshake: both ignored, sequence unchanged. A start on the done cycle restarts at idx 0, data 1.
- rst_n pulsed low during MUL of idx 50: all outputs go to 0 asynchronously, with no done pulse. A subsequent start yields 1, 17, ... again.
- TWIDDLE_INVERSE_EN defined, start with inv=1: outputs 1, 1175, 2419. Toggling inv mid-run does not alter the sequence. Output at idx 127 = 3312 (= -17 mod 3329).

Source files
------------

// File: rtl/twiddle_stream_gen.sv
// Streams ZETA^i mod Q (i = 0..N-1) over valid/ready; each power is computed with a bit-serial
// shift-add modular multiplier. Define TWIDDLE_INVERSE_EN to add the inv port (ZETA_INV^i sequence).
module twiddle_stream_gen #(
    parameter int unsigned Q        = 3329,
    parameter int unsigned ZETA     = 17,
`ifdef TWIDDLE_INVERSE_EN
    parameter int unsigned ZETA_INV = 1175,
`endif
    parameter int unsigned N        = 128,
    parameter int unsigned W        = 12,
    parameter int unsigned IW       = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          tw_ready,
`ifdef TWIDDLE_INVERSE_EN
    input  logic          inv,
`endif
    output logic          tw_valid,
    output logic [W-1:0]  tw_data,
    output logic [IW-1:0] tw_idx,
    output logic          busy,
    output logic          done
);

    localparam int unsigned BW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OUT,
        S_MUL
    } state_t;

    state_t          state_q;
    logic            tw_valid_q;
    logic [W-1:0]    tw_data_q;
    logic [IW-1:0]   tw_idx_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    opnd_q;
    logic [BW-1:0]   bit_q;
`ifdef TWIDDLE_INVERSE_EN
    logic            inv_q;
`endif

    logic [W:0]      c_ext;
    logic [W:0]      dbl;
    logic [W:0]      dbl_red;
    logic [W:0]      sum;
    logic [W:0]      sum_red;
    logic [W-1:0]    acc_d;

    // One MSB-first multiplier step: acc = 2*acc (+ C) mod Q, reduced after each operation.
    always_comb begin
        c_ext = (W+1)'(ZETA);
`ifdef TWIDDLE_INVERSE_EN
        if (inv_q) begin
            c_ext = (W+1)'(ZETA_INV);
        end
`endif
        dbl     = {acc_q, 1'b0};
        dbl_red = (dbl >= (W+1)'(Q)) ? dbl - (W+1)'(Q) : dbl;
        sum     = opnd_q[bit_q] ? dbl_red + c_ext : dbl_red;
        sum_red = (sum >= (W+1)'(Q)) ? sum - (W+1)'(Q) : sum;
        acc_d   = W'(sum_red);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tw_valid_q <= 1'b0;
            tw_data_q  <= '0;
            tw_idx_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            bit_q      <= '0;
`ifdef TWIDDLE_INVERSE_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_OUT;
                        tw_data_q  <= W'(1);
                        tw_idx_q   <= '0;
                        tw_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef TWIDDLE_INVERSE_EN
                        inv_q      <= inv;
`endif
                    end
                end
                S_OUT: begin
                    if (tw_ready) begin
                        tw_valid_q <= 1'b0;
                        if (tw_idx_q == IW'(N - 1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_MUL;
                            acc_q   <= '0;
                            bit_q   <= BW'(W - 1);
                            opnd_q  <= tw_data_q;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    if (bit_q == '0) begin
                        state_q    <= S_OUT;
                        tw_data_q  <= acc_d;
                        tw_idx_q   <= tw_idx_q + IW'(1);
                        tw_valid_q <= 1'b1;
                    end else begin
                        bit_q <= bit_q - BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tw_valid = tw_valid_q;
    assign tw_data  = tw_data_q;
    assign tw_idx   = tw_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Scoreboard bench for twiddle_stream_gen: expected powers are queued at start and popped
// at every observed handshake.
module tb_twiddle_stream_gen;

    localparam int unsigned Q    = 3329;
    localparam int unsigned ZETA = 17;
    localparam int unsigned ZINV = 1175;
    localparam int unsigned N    = 128;
    localparam int unsigned W    = 12;
    localparam int unsigned IW   = 7;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          tw_ready;
    logic          inv;
    logic          tw_valid;
    logic [W-1:0]  tw_data;
    logic [IW-1:0] tw_idx;
    logic          busy;
    logic          done;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_err;
    int          cyc;
    int          hs_cnt;
    int          done_cnt;
    int          last_hs_cyc;
    int unsigned last_data;
    bit          chk_spacing;
    int unsigned ref_first[5];
    int          ref_n;

    twiddle_stream_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tw_ready (tw_ready),
`ifdef TWIDDLE_INVERSE_EN
        .inv      (inv),
`endif
        .tw_valid (tw_valid),
        .tw_data  (tw_data),
        .tw_idx   (tw_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scores a handshake about to happen on the coming edge, then advances one clock.
    task automatic tick();
        exp_t e;
        if (tw_valid && tw_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("data", 32'(tw_data), 32'(e.data));
                check_eq("idx", 32'(tw_idx), 32'(e.idx));
            end
            check_eq("lt_q", 32'(tw_data < W'(Q)), 32'd1);
            if (int'(tw_idx) < ref_n) begin
                check_eq("ref_val", 32'(tw_data), ref_first[tw_idx]);
            end
            if (chk_spacing && hs_cnt > 0) begin
                check_eq("spacing", 32'(cyc - last_hs_cyc), 32'(W + 1));
            end
            last_hs_cyc = cyc;
            last_data   = 32'(tw_data);
            hs_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) done_cnt++;
    endtask

    task automatic start_seq(input int unsigned c);
        int unsigned p;
        p = 1;
        for (int i = 0; i < int'(N); i++) begin
            exp_q.push_back('{idx: IW'(i), data: W'(p)});
            p = (p * c) % Q;
        end
        hs_cnt   = 0;
        done_cnt = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_until_hs(input int target);
        int budget;
        budget = int'(N * (W + 1)) + 100;
        while (hs_cnt < target && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check_eq("timeout_hs", 32'(hs_cnt), 32'(target));
    endtask

    task automatic wait_valid(output int edges);
        int budget;
        edges  = 0;
        budget = 100;
        while (!tw_valid && budget > 0) begin
            tick();
            edges++;
            budget--;
        end
        if (budget == 0) check_eq("timeout_valid", 32'(tw_valid), 32'd1);
    endtask

    task automatic run_to_end(input int unsigned last_exp);
        run_until_hs(int'(N));
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_low", 32'(busy), 32'd0);
        check_eq("valid_low", 32'(tw_valid), 32'd0);
        check_eq("last_data", last_data, last_exp);
        check_eq("hold_idx", 32'(tw_idx), 32'(N - 1));
        tick();
        check_eq("done_once", 32'(done), 32'd0);
        check_eq("done_cnt", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int edges;
        n_cmp = 0; n_err = 0; cyc = 0; hs_cnt = 0; done_cnt = 0;
        last_hs_cyc = 0; last_data = 0; chk_spacing = 1'b0;
        ref_first = '{1, 17, 289, 1584, 296};
        ref_n = 5;
        rst_n = 1'b0; start = 1'b0; tw_ready = 1'b0; inv = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(tw_valid), 32'd0);
        check_eq("rst_data", 32'(tw_data), 32'd0);
        check_eq("rst_idx", 32'(tw_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full forward run, ready always high
        tw_ready = 1'b1;
        chk_spacing = 1'b1;
        start_seq(ZETA);
        check_eq("first_valid", 32'(tw_valid), 32'd1);
        check_eq("first_busy", 32'(busy), 32'd1);
        run_to_end(2154);
        chk_spacing = 1'b0;

        // Backpressure at idx 2
        start_seq(ZETA);
        run_until_hs(2);
        tw_ready = 1'b0;
        wait_valid(edges);
        for (int k = 0; k < 20; k++) begin
            check_eq("bp_valid", 32'(tw_valid), 32'd1);
            check_eq("bp_data", 32'(tw_data), 32'd289);
            tick();
        end
        tw_ready = 1'b1;
        tick();
        wait_valid(edges);
        check_eq("bp_latency", 32'(edges), 32'(W));
        check_eq("bp_next", 32'(tw_data), 32'd1584);
        run_to_end(2154);

        // Ignored starts at idx 10, in MUL and on the final handshake; restart on done
        start_seq(ZETA);
        while (!(tw_valid && tw_idx == IW'(10)) && hs_cnt < int'(N)) tick();
        start = 1'b1; tick(); start = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        run_until_hs(int'(N) - 1);
        wait_valid(edges);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("final_done", 32'(done), 32'd1);
        check_eq("final_last", last_data, 32'd2154);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        start_seq(ZETA);
        check_eq("restart_valid", 32'(tw_valid), 32'd1);
        check_eq("restart_idx", 32'(tw_idx), 32'd0);
        check_eq("restart_data", 32'(tw_data), 32'd1);

        // Reset during the multiply producing idx 50
        run_until_hs(50);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(tw_valid), 32'd0);
        check_eq("arst_data", 32'(tw_data), 32'd0);
        check_eq("arst_idx", 32'(tw_idx), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("arst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("arst_no_done", 32'(done_cnt), 32'd0);
        start_seq(ZETA);
        run_to_end(2154);

`ifdef TWIDDLE_INVERSE_EN
        // Inverse sequence, inv toggled mid-run
        ref_first = '{1, 1175, 2419, 0, 0};
        ref_n = 3;
        inv = 1'b1;
        start_seq(ZINV);
        run_until_hs(20);
        inv = 1'b0;
        repeat (7) tick();
        inv = 1'b1;
        run_to_end(3312);
        inv = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
